// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank scheduler: command encoding, FSM states
// and default timing.
package dram_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam int DEF_T_RP  = 2;
  localparam int DEF_T_RCD = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_ACT      = 3'd3,
    ST_WAIT_RCD = 3'd4,
    ST_RW       = 3'd5
  } state_t;

  // Command driven on the bus while the FSM sits in a given state.
  function automatic logic [1:0] state_cmd(input state_t st);
    logic [1:0] c;
    case (st)
      ST_PRE:  c = CMD_PRE;
      ST_ACT:  c = CMD_ACT;
      ST_RW:   c = CMD_RW;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dram_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping from the last index back to 0.
module dram_rr_arbiter #(
  parameter  int NUM_OF_REQ = 8,
  localparam int IW         = $clog2(NUM_OF_REQ)
) (
  input  logic [NUM_OF_REQ-1:0] req,
  input  logic [IW-1:0]         ptr,
  output logic [NUM_OF_REQ-1:0] grant,
  output logic [IW-1:0]         grant_idx,
  output logic                  any
);

  logic [IW-1:0] cand_s;

  // Scan from ptr upward; the first pending requester is latched as winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_s    = '0;
    for (int i = 0; i < NUM_OF_REQ; i++) begin
      cand_s = IW'((int'(ptr) + i) % NUM_OF_REQ);
      if (!any && req[cand_s]) begin
        any           = 1'b1;
        grant_idx     = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/dram_bank_scheduler.sv
// Single-outstanding DRAM request scheduler: round-robin pick, open-row
// tracking per bank and PRE/ACT/RW sequencing with tRP/tRCD spacing.
module dram_bank_scheduler
  import dram_pkg::*;
#(
  parameter  int NUM_OF_REQ   = 8,
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  parameter  int NUM_OF_COLS  = 8,
  parameter  int T_RP         = DEF_T_RP,
  parameter  int T_RCD        = DEF_T_RCD,
  localparam int BW           = $clog2(NUM_OF_BANKS),
  localparam int RW_          = $clog2(NUM_OF_ROWS),
  localparam int CW           = $clog2(NUM_OF_COLS),
  localparam int IW           = $clog2(NUM_OF_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_OF_REQ-1:0]    req_valid,
  input  logic [NUM_OF_REQ-1:0]    req_we,
  input  logic [NUM_OF_REQ*BW-1:0] req_bank,
  input  logic [NUM_OF_REQ*RW_-1:0] req_row,
  input  logic [NUM_OF_REQ*CW-1:0] req_col,
  output logic [NUM_OF_REQ-1:0]    req_ready,
  output logic [1:0]               cmd,
  output logic                     cmd_we,
  output logic [BW-1:0]            cmd_bank,
  output logic [RW_-1:0]           cmd_row,
  output logic [CW-1:0]            cmd_col,
  output logic [IW-1:0]            grant_id,
  output logic                     busy
);

  state_t               state_r, state_nxt_s;
  logic [IW-1:0]        rr_ptr_r, win_idx_s, cur_id_s;
  logic [NUM_OF_REQ-1:0] win_oh_s;
  logic                 win_any_s;
  logic [BW-1:0]        bank_r, win_bank_s, cur_bank_s;
  logic [RW_-1:0]       row_r, win_row_s, cur_row_s;
  logic [CW-1:0]        col_r, win_col_s, cur_col_s;
  logic                 we_r, win_we_s, cur_we_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_OF_BANKS-1:0] open_vld_r;
  logic [RW_-1:0]       open_row_r [NUM_OF_BANKS];

  dram_rr_arbiter #(.NUM_OF_REQ(NUM_OF_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (win_oh_s),
    .grant_idx (win_idx_s),
    .any       (win_any_s)
  );

  assign win_bank_s = req_bank[int'(win_idx_s)*BW +: BW];
  assign win_row_s  = req_row[int'(win_idx_s)*RW_ +: RW_];
  assign win_col_s  = req_col[int'(win_idx_s)*CW +: CW];
  assign win_we_s   = req_we[win_idx_s];

  // In IDLE the request being decided comes straight from the arbiter.
  assign cur_bank_s = (state_r == ST_IDLE) ? win_bank_s : bank_r;
  assign cur_row_s  = (state_r == ST_IDLE) ? win_row_s  : row_r;
  assign cur_col_s  = (state_r == ST_IDLE) ? win_col_s  : col_r;
  assign cur_we_s   = (state_r == ST_IDLE) ? win_we_s   : we_r;
  assign cur_id_s   = (state_r == ST_IDLE) ? win_idx_s  : grant_id;

  // Next-state decision, including the hit/closed/conflict lookup.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!win_any_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!open_vld_r[win_bank_s]) begin
          state_nxt_s = ST_ACT;
        end else if (open_row_r[win_bank_s] == win_row_s) begin
          state_nxt_s = ST_RW;
        end else begin
          state_nxt_s = ST_PRE;
        end
      end
      ST_PRE:      state_nxt_s = (T_RP > 1) ? ST_WAIT_RP : ST_ACT;
      ST_WAIT_RP:  state_nxt_s = (cnt_r == {CNT_W{1'b0}}) ? ST_ACT : ST_WAIT_RP;
      ST_ACT:      state_nxt_s = (T_RCD > 1) ? ST_WAIT_RCD : ST_RW;
      ST_WAIT_RCD: state_nxt_s = (cnt_r == {CNT_W{1'b0}}) ? ST_RW : ST_WAIT_RCD;
      ST_RW:       state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant bookkeeping, latched request fields and the tRP/tRCD counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr_r <= '0;
      bank_r   <= '0;
      row_r    <= '0;
      col_r    <= '0;
      we_r     <= 1'b0;
      grant_id <= '0;
      cnt_r    <= '0;
    end else begin
      if (state_r == ST_IDLE && win_any_s) begin
        bank_r   <= win_bank_s;
        row_r    <= win_row_s;
        col_r    <= win_col_s;
        we_r     <= win_we_s;
        grant_id <= win_idx_s;
        rr_ptr_r <= (win_idx_s == IW'(NUM_OF_REQ-1)) ? {IW{1'b0}} : win_idx_s + 1'b1;
      end
      // The loaded value is only consumed when the matching wait state exists.
      if (state_r == ST_PRE) begin
        cnt_r <= CNT_W'(T_RP - 2);
      end else if (state_r == ST_ACT) begin
        cnt_r <= CNT_W'(T_RCD - 2);
      end else if (cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

  // Open-row table: closed on PRE, opened with the new row on ACT.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      open_vld_r <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        open_row_r[b] <= '0;
      end
    end else begin
      if (state_nxt_s == ST_PRE) begin
        open_vld_r[cur_bank_s] <= 1'b0;
      end
      if (state_nxt_s == ST_ACT) begin
        open_vld_r[cur_bank_s] <= 1'b1;
        open_row_r[cur_bank_s] <= cur_row_s;
      end
    end
  end

  // Registered command bus; fields hold unless their command is issued.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cmd       <= CMD_NOP;
      cmd_we    <= 1'b0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
    end else begin
      cmd       <= state_cmd(state_nxt_s);
      busy      <= (state_nxt_s != ST_IDLE);
      req_ready <= (state_nxt_s == ST_RW) ? (NUM_OF_REQ'(1'b1) << cur_id_s) : {NUM_OF_REQ{1'b0}};
      if (state_cmd(state_nxt_s) != CMD_NOP) begin
        cmd_bank <= cur_bank_s;
      end
      if (state_nxt_s == ST_ACT) begin
        cmd_row <= cur_row_s;
      end
      if (state_nxt_s == ST_RW) begin
        cmd_col <= cur_col_s;
        cmd_we  <= cur_we_s;
      end
    end
  end

endmodule

// File: doc/dram_bank_scheduler.md
# dram_bank_scheduler

Request scheduler that sits between the per-requester L2 request buffers and the DRAM command/decoder path. It selects one pending request at a time from 8 requesters using round-robin arbitration. It tracks the open row of every bank and issues the PRE/ACT/RW command sequence with programmable tRP/tRCD spacing. When the RW command issues, it returns a one-cycle ready to the winning requester.

## Interface
- NUM_OF_REQ, 8, number of requesters
- NUM_OF_BANKS, 8, banks; BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank; RW_ = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row; CW = $clog2(NUM_OF_COLS)
- T_RP, 2, cycles from PRE to ACT (≥1)
- T_RCD, 2, cycles from ACT to RW (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_OF_REQ  per-requester pending request
- req_we  in  NUM_OF_REQ  1 = write, 0 = read
- req_bank  in  NUM_OF_REQ*BW  flattened bank ids; requester i at [i*BW +: BW]
- req_row  in  NUM_OF_REQ*RW_  flattened row ids
- req_col  in  NUM_OF_REQ*CW  flattened column ids
- req_ready  out  NUM_OF_REQ  one-hot, one-cycle accept pulse
- cmd  out  2  00 NOP, 01 ACT, 10 RW, 11 PRE
- cmd_we  out  1  valid with cmd=RW; 1 = write
- cmd_bank  out  BW  target bank of the current cmd
- cmd_row  out  RW_  row for ACT
- cmd_col  out  CW  column for RW
- grant_id  out  $clog2(NUM_OF_REQ)  index of the requester being serviced
- busy  out  1  high while a request is in flight (any state except IDLE)

## Operation
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW.
- IDLE: if any req_valid, round-robin pick starting at rr_ptr. Latch winner index, bank/row/col/we. Set rr_ptr = winner+1 (mod NUM_OF_REQ).
- Next state from the open-row table, indexed by bank:
  - hit (open_vld && open_row==row) → RW
  - closed (!open_vld) → ACT
  - conflict (open_vld, different row) → PRE
- PRE: cmd=11, clear open_vld[bank]. Next is WAIT_RP if T_RP>1 (counter loaded with T_RP-2), else ACT.
- WAIT_RP: cmd=00; when counter==0 → ACT, else decrement.
- ACT: cmd=01, cmd_row=latched row, set open_vld[bank]=1 and open_row[bank]=row. Next is WAIT_RCD (counter loaded with T_RCD-2) if T_RCD>1, else RW.
- WAIT_RCD: as WAIT_RP, then → RW.
- RW: cmd=10, cmd_col/cmd_we driven, req_ready[grant_id]=1 for this cycle only → IDLE. The row stays open (open-page policy).
- Requester contract: req_valid and its fields stay stable from assertion until req_ready. Fields are sampled only in the IDLE grant cycle. Later changes before ready are ignored. Dropping valid before ready is illegal; it is not checked.
- Only one request in flight; no reordering beyond the RR pick.
- Outside their valid commands, cmd_* hold their last value; checkers must qualify them with cmd.

## Timing
- Reset values: cmd=00, cmd_we=0, cmd_bank/row/col=0, req_ready=0, grant_id=0, busy=0. open_vld all 0, rr_ptr=0, state IDLE.
- All outputs are registered; cmd is visible the cycle after the state decision.
- Grant in cycle N; then:
  - hit: RW and ready at N+1
  - closed: ACT at N+1, RW at N+1+T_RCD
  - conflict: PRE at N+1, ACT at N+1+T_RP, RW at N+1+T_RP+T_RCD
- Back-to-back: the earliest next grant is in the cycle after RW (IDLE). So consecutive hits give RW every 2 cycles.
- Simultaneous valids: the lowest index at or after rr_ptr wins. Wrap from NUM_OF_REQ-1 to 0.
- Reset asserted mid-sequence: immediate return to IDLE and all table entries closed; no pulse on req_ready.

## Structure
- Shared package dram_pkg: cmd encoding localparams (CMD_NOP/ACT/RW/PRE), state enum, default timing constants.
- Sub-module dram_rr_arbiter (NUM_OF_REQ): req vector + ptr in → one-hot grant and index out, combinational.
- The open-row table (NUM_OF_BANKS × {vld, row}) and the timing counter live in the top module.

## Test plan
- Cold access: after reset, req0 valid bank2 row5 col3 read → ACT bank2 row5 at N+1, RW col3 at N+3 (T_RCD=2), req_ready=0000_0001 for one cycle.
- Row hit: repeat req0 bank2 row5 col6 write → RW at N+1 with cmd_we=1, no ACT/PRE.
- Row conflict: req1 bank2 row9 → PRE N+1, ACT row9 N+3, RW N+5; later hit on row9 confirms the table update.
- Round robin: all 8 valid on distinct banks, rr_ptr=0 → grants in order 0,1,…,7. Then with req3 and req7 held valid, grants alternate 3,7,3.
- Timing params: T_RP=1, T_RCD=1 conflict → PRE, ACT, RW on three consecutive cycles; no WAIT states entered.
- Mid-op reset: drop rst_b during WAIT_RCD → all outputs 0 asynchronously. After release, the same request triggers ACT (table cleared).
